instruction_fetch: RTL

Fetch stage of the single-cycle-fetch ARM pipeline. Holds the program counter and drives the byte address into the combinational big-endian instruction memory. Registers the returned 32-bit word, with its PC, into the IF/ID pipeline register consumed by the decoder. Handles stall from hazard logic and redirect from the branch/execute stage, inserting bubbles on redirect.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/pc_reg.sv | 45 ++++
 rtl/instruction_fetch.sv | 101 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   state_e        : fetch-stage FSM states (BOOT, RUN, FLUSH)
//   WORD_W         : datapath / address width
//   PC_INC         : byte stride between sequential instructions
//   PC_READ_OFFSET : ARM-visible PC offset seen by operand reads
//   NOP_WORD       : bubble instruction (andeq r0,r0,r0)
//   align_word()   : clears the byte-offset bits of an address
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] PC_INC         = 32'd4;
  localparam logic [WORD_W-1:0] PC_READ_OFFSET = 32'd8;
  localparam logic [WORD_W-1:0] NOP_WORD       = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk           : system clock
//   reset         : synchronous active-high reset, loads RESET_PC
//   redirect_i    : load the aligned redirect target
//   redirect_pc_i : redirect target, low two bits dropped
//   stall_i       : hold the current PC
//   pc_o          : current PC, always word-aligned
// Priority: reset > redirect > stall > increment.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  input  logic              stall_i,
  output logic [WORD_W-1:0] pc_o
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = align_word(redirect_pc_i);
    end else if (!stall_i) begin
      // Wraps naturally modulo 2^32.
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, presents it to instruction memory and captures
// the returned word into the IF/ID register. Redirects insert one bubble.
//   clk, reset   : clock, synchronous active-high reset
//   stall        : hold PC and IF/ID contents
//   redirect     : load redirect_pc (word-aligned), emit a bubble
//   redirect_pc  : redirect target
//   imem_addr    : byte address to instruction memory (registered PC)
//   imem_data    : combinational instruction word for imem_addr
//   if_instr     : registered instruction for decode
//   if_pc        : fetch address of if_instr
//   if_pc8       : if_pc + 8
//   if_valid     : if_instr is a real instruction
//   fetch_count  : count of instructions delivered with if_valid=1
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc8,
  output logic        if_valid,
  output logic [31:0] fetch_count
);

  state_e      state_q, state_d;
  logic [31:0] pc;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .reset        (reset),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .stall_i      (stall),
    .pc_o         (pc)
  );

  always_comb begin
    state_d       = state_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // Redirect beats stall; if_pc keeps its last value under the bubble.
      if_instr_d = NOP_WORD;
      if_valid_d = 1'b0;
      state_d    = FLUSH;
    end else if (!stall) begin
      // BOOT, RUN and FLUSH all fetch identically when unstalled; BOOT and
      // FLUSH then settle into RUN.
      if_instr_d    = imem_data;
      if_pc_d       = pc;
      if_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
      case (state_q)
        BOOT, RUN, FLUSH: state_d = RUN;
        default:          state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      if_instr_q    <= NOP_WORD;
      if_pc_q       <= 32'd0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc8      = if_pc_q + PC_READ_OFFSET;
  assign if_valid    = if_valid_q;
  assign fetch_count = fetch_count_q;

endmodule
